serdes_pattern_tester: RTL and testbench
========================================

# serdes_pattern_tester

Synthesizable, parametrised stimulus generator and loopback checker for the serializer path. Each word is held for WIDTH clocks. The block drives framed parallel words (`data`, `enb`, `dk`) into the serializer under test. It receives the serial stream back, aligns on a comma word, deserializes it and compares it against an internally regenerated expected sequence. It replaces the fixed single-word bench stimulus and reports lock, word count and error count.

## Interface
- `WIDTH`, 8: parallel word width; also the number of bits per serialized word.
- `COMMA`, 8'hBC: control word sent with `dk`=1; used for alignment.
- `COMMA_GAP`, 4: number of data words between consecutive commas (≥1).
- `SEED`, 8'hFF: LFSR initial value (non-zero).
- `TAPS`, 8'hB8: Galois LFSR tap mask.
- `CNT_W`, 16: width of the counters.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; generator runs while high.
- `mode`  in  1  0 = incrementing pattern, 1 = LFSR pattern; sampled at each comma.
- `data`  out  WIDTH  word to serializer.
- `enb`  out  1  word valid / serializer enable.
- `dk`  out  1  1 = current word is the comma (control) word.
- `serial_in`  in  1  serialized loopback, MSB first, one bit per clk.
- `locked`  out  1  checker is aligned.
- `word_cnt`  out  CNT_W  words checked while locked; saturating.
- `err_cnt`  out  CNT_W  mismatching data words; saturating.

## Operation
- Generator FSM states: IDLE, COMMA, DATA. A slot counter runs 0..WIDTH-1, and a new word is loaded when the counter wraps.
- IDLE → COMMA on the first clk with `start`=1. COMMA lasts one word, then DATA for COMMA_GAP words, then COMMA again.
- When `start`=0 at a word boundary, the FSM goes to IDLE. The current word always completes.
- COMMA: `data`=COMMA, `dk`=1. DATA: `dk`=0. `enb`=1 in COMMA and DATA, 0 in IDLE.
- The pattern restarts after every comma. Mode 0 produces 0,1,2,… (mod 2^WIDTH). Mode 1 produces SEED, then next = (x>>1) ^ (x[0] ? TAPS : 0).
- Checker hunt state: a WIDTH-bit shift register takes `serial_in` into its LSB every clk. When the register equals COMMA, `locked` goes to 1, the bit counter clears and the expected generator restarts.
- Checker locked state: a word is captured every WIDTH clocks. Captured words follow the same COMMA + COMMA_GAP schedule as the generator.
  - Data slot mismatch: `err_cnt` increments and lock is held.
  - Comma slot mismatch: `locked` drops to 0 and the checker returns to hunt. `err_cnt` is not incremented.
  - Every captured word in the locked state increments `word_cnt`.
- Both counters saturate at all-ones.
- The checker is independent of loopback latency because alignment comes only from the comma.

## Timing
- Reset values: `data`=0, `enb`=0, `dk`=0, `locked`=0, `word_cnt`=0, `err_cnt`=0, FSMs in IDLE/hunt, slot counters at 0.
- First word latency: `enb`, `dk` and `data`=COMMA are registered on the first rising edge with `start`=1 and are held for WIDTH clocks.
- Outputs change only at word boundaries.
- `locked` rises on the clk edge after the final comma bit is shifted in.
- Counter updates are registered one clk after word capture.
- Simultaneous comma-slot mismatch and a comma pattern in the shift register: the drop to hunt takes priority; re-lock can occur on the next matching edge.
- `reset` mid-word clears everything immediately; no partial word is reported.

## Structure
- Shared package `serdes_tester_pkg` holds:
  - the generator and checker state enums;
  - the default COMMA, SEED and TAPS constants;
  - the `lfsr_next` function.
- Sub-module `serdes_pattern_gen` (word-pattern source with restart, advance and mode inputs) is instantiated twice: once in the generator, once as the checker's expected source.

## Test plan
- Reset, then `start`=1, `mode`=0, WIDTH=8: `dk`/`data` sequence BC(1), 00, 01, 02, 03, BC(1), 00…, each word held 8 clks.
- `mode`=1: data words after the comma are FF, C7, DB, D5, then BC again.
- Ideal serializer model, MSB first, 3-clk delay, 20 words: `locked`=1 after the first comma, `err_cnt`=0, `word_cnt` counts every word.
- Flip bit 0 of the third data word in the loopback: `err_cnt`=1 and `locked` stays 1.
- Corrupt one comma to 8'hBD: `locked` drops to 0, re-locks on the next comma, `err_cnt` unchanged.
- Assert `reset` mid-word, then force `err_cnt` toward all-ones: all outputs return to reset values immediately, and the counter holds at 16'hFFFF on further errors.

Source files
------------

// File: rtl/serdes_tester_pkg.sv
// Shared types, default constants and the LFSR step for the serdes pattern tester.
// The generator and the checker both use these definitions.
package serdes_tester_pkg;

   typedef enum logic [1:0] {GEN_IDLE, GEN_COMMA, GEN_DATA} gen_state_t;
   typedef enum logic {CHK_HUNT, CHK_LOCKED} chk_state_t;

   localparam logic [7:0] DEF_COMMA = 8'hBC;
   localparam logic [7:0] DEF_SEED  = 8'hFF;
   localparam logic [7:0] DEF_TAPS  = 8'hB8;

   // Galois step on a 32-bit container; callers cast the result back to their width (<= 32).
   function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] taps);
      return (x >> 1) ^ (x[0] ? taps : 32'd0);
   endfunction

endpackage

// File: rtl/serdes_pattern_gen.sv
// Word-pattern source: restart loads the first word of the selected pattern
// (mode latched at restart), advance steps to the next word.
module serdes_pattern_gen
   import serdes_tester_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_restart,
   input  logic             i_advance,
   input  logic             i_mode,
   output logic [WIDTH-1:0] o_word
);

   logic             r_mode;
   logic [WIDTH-1:0] r_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= 1'b0;
         r_word <= '0;
      end else if (i_restart) begin
         r_mode <= i_mode;
         r_word <= i_mode ? SEED : '0;
      end else if (i_advance) begin
         r_word <= r_mode ? WIDTH'(lfsr_next(32'(r_word), 32'(TAPS))) : r_word + WIDTH'(1);
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/serdes_pattern_tester.sv
// Framed stimulus generator for the serializer plus a comma-aligned loopback
// checker that regenerates the expected stream and counts words and errors.
module serdes_pattern_tester
   import serdes_tester_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] COMMA     = WIDTH'(DEF_COMMA),
   parameter int unsigned      COMMA_GAP = 4,
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   output logic [WIDTH-1:0] data,
   output logic             enb,
   output logic             dk,
   input  logic             serial_in,
   output logic             locked,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int               SLOT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int               GAP_W     = $clog2(COMMA_GAP + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(COMMA_GAP - 1);
   localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(COMMA_GAP);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   gen_state_t        r_gen_state, w_gen_next;
   logic [SLOT_W-1:0] r_slot;
   logic [GAP_W-1:0]  r_gap;
   logic [WIDTH-1:0]  r_data, w_data_nxt, w_gen_word;
   logic              r_enb, r_dk, w_enb_nxt, w_dk_nxt;
   logic              w_boundary, w_word_load, w_gen_restart, w_gen_advance;

   assign w_boundary = (r_slot == SLOT_LAST);

   always_comb begin
      w_gen_next    = r_gen_state;
      w_word_load   = 1'b0;
      w_gen_restart = 1'b0;
      w_gen_advance = 1'b0;
      w_data_nxt    = '0;
      w_dk_nxt      = 1'b0;
      w_enb_nxt     = 1'b0;
      unique case (r_gen_state)
         GEN_IDLE: if (start) begin
            w_gen_next  = GEN_COMMA;
            w_word_load = 1'b1;
         end
         GEN_COMMA: if (w_boundary) begin
            w_word_load = 1'b1;
            w_gen_next  = start ? GEN_DATA : GEN_IDLE;
         end
         GEN_DATA: if (w_boundary) begin
            w_word_load = 1'b1;
            if (!start)                 w_gen_next = GEN_IDLE;
            else if (r_gap == GAP_LAST) w_gen_next = GEN_COMMA;
            else                        w_gen_next = GEN_DATA;
         end
         default: w_gen_next = GEN_IDLE;
      endcase
      // The pattern source restarts with each comma so every frame begins at the first word.
      if (w_word_load) begin
         unique case (w_gen_next)
            GEN_COMMA: begin
               w_data_nxt    = COMMA;
               w_dk_nxt      = 1'b1;
               w_enb_nxt     = 1'b1;
               w_gen_restart = 1'b1;
            end
            GEN_DATA: begin
               w_data_nxt    = w_gen_word;
               w_enb_nxt     = 1'b1;
               w_gen_advance = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_gen_state <= GEN_IDLE;
      else       r_gen_state <= w_gen_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot <= '0;
         r_gap  <= '0;
         r_data <= '0;
         r_enb  <= 1'b0;
         r_dk   <= 1'b0;
      end else begin
         if (r_gen_state == GEN_IDLE || w_boundary) r_slot <= '0;
         else                                       r_slot <= r_slot + SLOT_W'(1);
         if (w_word_load) begin
            r_data <= w_data_nxt;
            r_dk   <= w_dk_nxt;
            r_enb  <= w_enb_nxt;
            if (w_gen_next == GEN_DATA)
               r_gap <= (r_gen_state == GEN_DATA) ? r_gap + GAP_W'(1) : '0;
         end
      end
   end

   serdes_pattern_gen #(.WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)) u_gen_pat (
      .clk       (clk),
      .reset     (reset),
      .i_restart (w_gen_restart),
      .i_advance (w_gen_advance),
      .i_mode    (mode),
      .o_word    (w_gen_word)
   );

   chk_state_t        r_chk_state, w_chk_next;
   logic [WIDTH-1:0]  r_shift, w_exp_word;
   logic [SLOT_W-1:0] r_bit;
   logic [GAP_W-1:0]  r_cgap;
   logic [CNT_W-1:0]  r_word_cnt, r_err_cnt;
   logic              w_comma_seen, w_capture, w_exp_restart, w_exp_advance;
   logic              w_word_done, w_data_err;

   assign w_comma_seen = (r_shift == COMMA);
   assign w_capture    = (r_chk_state == CHK_LOCKED) && (r_bit == SLOT_LAST);

   // A failed comma slot drops to hunt even if a fresh comma is forming; hunt re-checks next edge.
   always_comb begin
      w_chk_next    = r_chk_state;
      w_exp_restart = 1'b0;
      w_exp_advance = 1'b0;
      w_word_done   = 1'b0;
      w_data_err    = 1'b0;
      unique case (r_chk_state)
         CHK_HUNT: if (w_comma_seen) begin
            w_chk_next    = CHK_LOCKED;
            w_exp_restart = 1'b1;
         end
         CHK_LOCKED: if (w_capture) begin
            w_word_done = 1'b1;
            if (r_cgap == GAP_FULL) begin
               if (w_comma_seen) w_exp_restart = 1'b1;
               else              w_chk_next    = CHK_HUNT;
            end else begin
               w_exp_advance = 1'b1;
               w_data_err    = (r_shift != w_exp_word);
            end
         end
         default: w_chk_next = CHK_HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_chk_state <= CHK_HUNT;
      else       r_chk_state <= w_chk_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift    <= '0;
         r_bit      <= '0;
         r_cgap     <= '0;
         r_word_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_shift <= {r_shift[WIDTH-2:0], serial_in};
         if (r_chk_state == CHK_HUNT || w_capture) r_bit <= '0;
         else                                      r_bit <= r_bit + SLOT_W'(1);
         if (w_exp_restart)      r_cgap <= '0;
         else if (w_exp_advance) r_cgap <= r_cgap + GAP_W'(1);
         if (w_word_done) r_word_cnt <= sat_inc(r_word_cnt);
         if (w_data_err)  r_err_cnt  <= sat_inc(r_err_cnt);
      end
   end

   serdes_pattern_gen #(.WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)) u_exp_pat (
      .clk       (clk),
      .reset     (reset),
      .i_restart (w_exp_restart),
      .i_advance (w_exp_advance),
      .i_mode    (mode),
      .o_word    (w_exp_word)
   );

   assign data     = r_data;
   assign enb      = r_enb;
   assign dk       = r_dk;
   assign locked   = (r_chk_state == CHK_LOCKED);
   assign word_cnt = r_word_cnt;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_serdes_pattern_tester.sv
// Directed bench: generator word table, ideal MSB-first serializer loopback with
// 3-clk delay and injected bit faults, and a narrow-counter instance for saturation.
module tb_serdes_pattern_tester;

   logic        clk = 1'b0;
   logic        reset, start, mode, serial_in, sat_serial;
   logic [7:0]  data, s_data;
   logic        enb, dk, locked, s_enb, s_dk, s_locked;
   logic [15:0] word_cnt, err_cnt;
   logic [3:0]  s_word_cnt, s_err_cnt;

   always #5 clk = ~clk;

   serdes_pattern_tester dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .data(data), .enb(enb), .dk(dk), .serial_in(serial_in),
      .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt)
   );

   serdes_pattern_tester #(.CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .data(s_data), .enb(s_enb), .dk(s_dk), .serial_in(sat_serial),
      .locked(s_locked), .word_cnt(s_word_cnt), .err_cnt(s_err_cnt)
   );

   // Serializer model: slot/word index follow the held words; bit 0 of word flip_word is inverted.
   int         slot, widx, flip_word;
   logic [2:0] pipe, sat_pipe;
   logic       raw, sat_raw;

   always_comb begin
      raw     = 1'b0;
      sat_raw = 1'b0;
      if (enb) begin
         raw     = data[7-slot] ^ ((widx == flip_word) && (slot == 7));
         sat_raw = data[7-slot] ^ (!dk && (slot == 7));
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         slot     <= 0;
         widx     <= 0;
         pipe     <= '0;
         sat_pipe <= '0;
      end else begin
         if (!enb) begin
            slot <= 0;
            widx <= 0;
         end else if (slot == 7) begin
            slot <= 0;
            widx <= widx + 1;
         end else begin
            slot <= slot + 1;
         end
         pipe     <= {pipe[1:0], raw};
         sat_pipe <= {sat_pipe[1:0], sat_raw};
      end
   end

   assign serial_in  = pipe[2];
   assign sat_serial = sat_pipe[2];

   int checks = 0, failures = 0, cur = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Edge E0 is the first rising edge with start high; cur tracks the edge index.
   task automatic start_run();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cur = 0;
      #1;
   endtask

   task automatic goto(input int n);
      while (cur < n) begin
         @(posedge clk);
         cur++;
      end
      #1;
   endtask

   typedef struct {
      logic       mode;
      int         word;
      logic       dk;
      logic [7:0] data;
   } gen_vec_t;

   gen_vec_t gv[14];

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; flip_word = -1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 32'(data), 32'h0);
      chk("rst_enb", 32'(enb), 32'h0);
      chk("rst_dk", 32'(dk), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_word_cnt", 32'(word_cnt), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);

      gv[0]  = '{1'b0, 0, 1'b1, 8'hBC};
      gv[1]  = '{1'b0, 1, 1'b0, 8'h00};
      gv[2]  = '{1'b0, 2, 1'b0, 8'h01};
      gv[3]  = '{1'b0, 3, 1'b0, 8'h02};
      gv[4]  = '{1'b0, 4, 1'b0, 8'h03};
      gv[5]  = '{1'b0, 5, 1'b1, 8'hBC};
      gv[6]  = '{1'b0, 6, 1'b0, 8'h00};
      gv[7]  = '{1'b1, 0, 1'b1, 8'hBC};
      gv[8]  = '{1'b1, 1, 1'b0, 8'hFF};
      gv[9]  = '{1'b1, 2, 1'b0, 8'hC7};
      gv[10] = '{1'b1, 3, 1'b0, 8'hDB};
      gv[11] = '{1'b1, 4, 1'b0, 8'hD5};
      gv[12] = '{1'b1, 5, 1'b1, 8'hBC};
      gv[13] = '{1'b1, 6, 1'b0, 8'hFF};

      for (int i = 0; i < 14; i++) begin
         if (i == 0 || gv[i].mode != gv[i-1].mode) begin
            mode = gv[i].mode;
            do_reset();
            start_run();
         end
         goto(8 * gv[i].word);
         chk($sformatf("gen_m%0d_w%0d_enb", gv[i].mode, gv[i].word), 32'(enb), 32'h1);
         chk($sformatf("gen_m%0d_w%0d_dk", gv[i].mode, gv[i].word), 32'(dk), 32'(gv[i].dk));
         chk($sformatf("gen_m%0d_w%0d_data", gv[i].mode, gv[i].word), 32'(data), 32'(gv[i].data));
         goto(8 * gv[i].word + 7);
         chk($sformatf("hold_m%0d_w%0d_dk", gv[i].mode, gv[i].word), 32'(dk), 32'(gv[i].dk));
         chk($sformatf("hold_m%0d_w%0d_data", gv[i].mode, gv[i].word), 32'(data), 32'(gv[i].data));
      end

      // Dropping start mid-comma: the comma completes, then the generator idles.
      mode = 1'b0;
      do_reset();
      start_run();
      goto(3);
      start = 1'b0;
      goto(7);
      chk("stop_hold_enb", 32'(enb), 32'h1);
      chk("stop_hold_data", 32'(data), 32'hBC);
      goto(8);
      chk("stop_idle_enb", 32'(enb), 32'h0);
      chk("stop_idle_dk", 32'(dk), 32'h0);
      chk("stop_idle_data", 32'(data), 32'h0);

      // Clean loopback over 20 words.
      do_reset();
      flip_word = -1;
      start_run();
      goto(11);
      chk("clean_lock_early", 32'(locked), 32'h0);
      goto(12);
      chk("clean_lock", 32'(locked), 32'h1);
      goto(44);
      chk("clean_wc_4", 32'(word_cnt), 32'd4);
      chk("sat_err_4", 32'(s_err_cnt), 32'd4);
      chk("sat_wc_4", 32'(s_word_cnt), 32'd4);
      goto(165);
      chk("clean_locked_end", 32'(locked), 32'h1);
      chk("clean_wc_end", 32'(word_cnt), 32'd19);
      chk("clean_err_end", 32'(err_cnt), 32'd0);
      chk("sat_err_hold", 32'(s_err_cnt), 32'hF);
      chk("sat_wc_hold", 32'(s_word_cnt), 32'hF);
      chk("sat_locked", 32'(s_locked), 32'h1);

      // Asynchronous reset in the middle of a word.
      goto(170);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_data", 32'(data), 32'h0);
      chk("midrst_enb", 32'(enb), 32'h0);
      chk("midrst_dk", 32'(dk), 32'h0);
      chk("midrst_locked", 32'(locked), 32'h0);
      chk("midrst_wc", 32'(word_cnt), 32'h0);
      chk("midrst_err", 32'(err_cnt), 32'h0);
      chk("midrst_sat_err", 32'(s_err_cnt), 32'h0);
      do_reset();

      // Bit 0 of the third data word inverted.
      flip_word = 3;
      start_run();
      goto(35);
      chk("dflip_err_before", 32'(err_cnt), 32'd0);
      goto(36);
      chk("dflip_err_after", 32'(err_cnt), 32'd1);
      chk("dflip_locked", 32'(locked), 32'h1);
      goto(165);
      chk("dflip_err_end", 32'(err_cnt), 32'd1);
      chk("dflip_wc_end", 32'(word_cnt), 32'd19);
      chk("dflip_locked_end", 32'(locked), 32'h1);

      // Third comma corrupted to 8'hBD: lock drops, returns on the next comma.
      do_reset();
      flip_word = 10;
      start_run();
      goto(91);
      chk("cflip_locked_before", 32'(locked), 32'h1);
      goto(92);
      chk("cflip_dropped", 32'(locked), 32'h0);
      chk("cflip_err_drop", 32'(err_cnt), 32'd0);
      goto(131);
      chk("cflip_still_hunt", 32'(locked), 32'h0);
      goto(132);
      chk("cflip_relock", 32'(locked), 32'h1);
      goto(165);
      chk("cflip_wc_end", 32'(word_cnt), 32'd14);
      chk("cflip_err_end", 32'(err_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
